sff_stim_chk: RTL
=================

Name: sff_stim_chk

Overview:
- Self-checking stimulus/response stage for techmap simulation of negedge-clocked, async-active-low-set flops.
- Sits directly upstream and downstream of LANES mapped set-flops:
  - drives their d and set pins from a pseudo-random sequence;
  - samples their q and compares against a reference model.
- Reports pass/fail, error count and first failing vector index to the bench.

Parameters:
- LANES, 4, number of flops exercised in parallel (1..16).
- NUM_VECTORS, 256, vectors per run (1..65535).
- SET_PERIOD, 16, set_out pulses low on every vector index i with i % SET_PERIOD == SET_PERIOD-1 (2..65535).
- SEED, 16'hACE1, LFSR seed; 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  pulse; begins a run from IDLE or DONE.
- q_in  in  LANES  q outputs of the flops under test.
- d_out  out  LANES  d inputs to the flops.
- set_out  out  1  shared set input to the flops, active-low.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  16  mismatching vectors, saturating at 16'hFFFF.
- first_err_idx  out  16  index of the first mismatching vector; 16'hFFFF if none.

Behaviour:
- Reset: rst=0 at a posedge puts every output in its reset state:
  - state IDLE, d_out=0, set_out=1, busy=0, done=0, pass=0;
  - err_count=0, first_err_idx=16'hFFFF, LFSR=seed, idx=0.
  - Reset overrides start in the same cycle. Reset mid-run aborts at that edge; no partial result is kept.
- LFSR: 16-bit Galois, taps 16'hB400, shifts once per issued vector. d_out = lfsr[LANES-1:0] before the shift.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start=1 at edge t → RUN. The same edge:
    - issues vector 0;
    - clears err_count, first_err_idx and done;
    - reloads the LFSR from seed before issuing;
    - sets busy=1.
  - RUN: one vector per edge. Edge t+k issues vector k. After vector NUM_VECTORS-1 is issued (edge t+N-1), go to DRAIN.
  - DRAIN: edge t+N performs the final compare, then goes to DONE with done=1, busy=0, d_out held, set_out=1.
  - start while busy is ignored.
- Timing contract:
  - d_out/set_out change at posedge; the flop captures at the following negedge.
  - q_in is sampled at the next posedge.
  - Compare latency is exactly one cycle: the check of vector k happens at edge t+k+1.
- Reference model, registered each issue:
  - exp = all-ones if set_out==0, else d_out;
  - cmp_valid=1, cmp_idx=k.
  - A vector mismatches if q_in != exp at its compare edge (any lane).
  - On mismatch: err_count increments (saturating); first_err_idx is loaded only if it still equals 16'hFFFF.
- Set: set_out=0 for exactly one cycle on qualifying indices. On those vectors d_out is still driven from the LFSR, but the expectation is all ones.
- Width rules:
  - idx and counters are 16 bits.
  - The modulo on SET_PERIOD uses a separate down-counter; no divider.
- pass is registered together with done.

Decomposition:
- Package sff_test_pkg:
  - state enum (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1;
  - ERR_SAT=16'hFFFF, NO_ERR_IDX=16'hFFFF.
- One sub-module, lfsr16:
  - inputs clk, rst, load, seed, step; output state;
  - synchronous active-low reset.
- FSM, set-period counter, expectation register and error logic stay in sff_stim_chk.

Test Plan:
1. Reset: hold rst=0 for 2 edges with start=1 → d_out=0, set_out=1, busy=0, done=0, err_count=0, first_err_idx=16'hFFFF.
2. Golden loop: LANES=4, N=256, four behavioural negedge set-flops on d_out/set_out/q_in; start pulse at edge t → busy=1 after t; done=1, pass=1, err_count=0 after edge t+256.
3. Set injection: SET_PERIOD=16, N=64 → set_out low for exactly 4 single cycles (idx 15,31,47,63); q_in=4'hF sampled at each following edge; pass=1.
4. Stuck-at fault: force q_in[2]=0 → err_count equals the model count of vectors whose expected bit 2 is 1; first_err_idx equals the first such index; pass=0.
5. Reset mid-run: rst=0 at vector 100 → next edge IDLE, busy=0, set_out=1, err_count=0; a new start reproduces a d_out sequence bit-identical to the first run.
6. Saturation: N=65535, q_in=~expected → err_count reaches 16'hFFFF and stays; first_err_idx=0; done after edge t+65535.

Source files
------------

// File: rtl/sff_test_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sff_test_pkg : shared types/constants for the set-flop stim/checker  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sff_test_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] ERR_SAT      = 16'hFFFF;
   localparam logic [15:0] NO_ERR_IDX   = 16'hFFFF;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sff_stim_chk_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr16 : 16-bit Galois LFSR; load+step together yields next(seed)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr16
   import sff_test_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= seed;
      end else if (load) begin
         state <= step ? lfsr_next(seed) : seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule
`default_nettype wire

// File: rtl/sff_stim_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sff_stim_chk : drives LANES set-flops from an LFSR, checks q_in      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sff_stim_chk
   import sff_test_pkg::*;
#(
   parameter int unsigned LANES       = 4,
   parameter int unsigned NUM_VECTORS = 256,
   parameter int unsigned SET_PERIOD  = 16,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LANES-1:0] q_in,
   output logic [LANES-1:0] d_out,
   output logic             set_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] SET_LAST = 16'(SET_PERIOD - 1);

   state_t           state, next_state;
   logic [15:0]      idx, cur_idx, set_cnt, cur_cnt, lfsr_state;
   logic [15:0]      cmp_idx, err_next, first_next;
   logic [LANES-1:0] exp_q, vec_d;
   logic             launch, issue, last_issue, set_now, cmp_valid, mismatch;
   logic             unused_lfsr;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (launch),
      .seed  (SEED_EFF),
      .step  (issue),
      .state (lfsr_state)
   );

   assign unused_lfsr = ^lfsr_state;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start) next_state = last_issue ? DRAIN : RUN;
         RUN:        if (last_issue) next_state = DRAIN;
         DRAIN:      next_state = DONE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      launch = 1'b0;
      issue  = 1'b0;
      busy   = 1'b0;
      case (state)
         IDLE, DONE: begin
            launch = start;
            issue  = start;
         end
         RUN: begin
            issue = 1'b1;
            busy  = 1'b1;
         end
         DRAIN:   busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // A launch restarts index, set counter and LFSR from their initial values.
   assign cur_idx    = launch ? 16'd0 : idx;
   assign cur_cnt    = launch ? SET_LAST : set_cnt;
   assign vec_d      = launch ? SEED_EFF[LANES-1:0] : lfsr_state[LANES-1:0];
   assign set_now    = (cur_cnt == 16'd0);
   assign last_issue = issue && (cur_idx == LAST_IDX);

   assign mismatch   = cmp_valid && (q_in != exp_q);
   assign err_next   = (mismatch && err_count != ERR_SAT) ? err_count + 16'd1 : err_count;
   assign first_next = (mismatch && first_err_idx == NO_ERR_IDX) ? cmp_idx : first_err_idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         d_out         <= '0;
         set_out       <= 1'b1;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= 16'd0;
         first_err_idx <= NO_ERR_IDX;
         idx           <= 16'd0;
         set_cnt       <= SET_LAST;
         exp_q         <= '0;
         cmp_valid     <= 1'b0;
         cmp_idx       <= 16'd0;
      end else begin
         set_out   <= 1'b1;
         cmp_valid <= issue;
         if (issue) begin
            d_out   <= vec_d;
            set_out <= !set_now;
            exp_q   <= set_now ? '1 : vec_d;
            cmp_idx <= cur_idx;
            idx     <= cur_idx + 16'd1;
            set_cnt <= set_now ? SET_LAST : cur_cnt - 16'd1;
         end
         if (launch) begin
            err_count     <= 16'd0;
            first_err_idx <= NO_ERR_IDX;
            done          <= 1'b0;
            pass          <= 1'b0;
         end else begin
            err_count     <= err_next;
            first_err_idx <= first_next;
         end
         if (state == DRAIN) begin
            done <= 1'b1;
            pass <= (err_next == 16'd0);
         end
      end
   end

endmodule
`default_nettype wire
